huffman_param_encoder: RTL and testbench

Parametrised successor to the fixed 6-symbol Huffman block. It histograms a stream of symbols 1..NSYM, publishes the counts, then builds a Huffman code by merging one pair of nodes per clock. It presents a per-symbol code and mask, held stable until the consumer acknowledges. It sits between the pixel/symbol source and the bitstream packer, and supports zero-count exclusion, saturating counts and an ack handshake.

---
 rtl/huffman_param_encoder.sv | 188 ++++++++++++++++++
 tb/tb_huffman_param_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/huffman_param_encoder.sv
// Parametrised Huffman encoder: histograms symbols 1..NSYM, then merges one node
// pair per clock to build right-aligned codes and masks, held until code_ack.
module huffman_param_encoder #(
    parameter int NSYM   = 6,
    parameter int SYM_W  = 8,
    parameter int CNT_W  = 8,
    parameter int CODE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_valid,
    input  logic [SYM_W-1:0]       gray_data,
    output logic                   cnt_valid,
    output logic [NSYM*CNT_W-1:0]  cnt_flat,
    output logic                   cnt_sat,
    output logic                   code_valid,
    input  logic                   code_ack,
    output logic [NSYM*CODE_W-1:0] hc_flat,
    output logic [NSYM*CODE_W-1:0] m_flat,
    output logic                   busy
);

    // Merged weights need clog2(NSYM) extra bits so the root sum never wraps.
    localparam int WW    = CNT_W + $clog2(NSYM);
    localparam int IDX_W = $clog2(NSYM);
    localparam int NUM_W = $clog2(NSYM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, RECV, CNT_OUT, BUILD, DONE} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0]  cnt     [NSYM];
    logic [NSYM-1:0]   active;
    logic [WW-1:0]     weight  [NSYM];
    logic [NUM_W-1:0]  tag     [NSYM];
    logic [NSYM-1:0]   members [NSYM];
    logic [CODE_W-1:0] hc      [NSYM];
    logic [CODE_W-1:0] m       [NSYM];

    logic [NSYM-1:0]  hit;
    logic [NSYM-1:0]  nonzero;
    logic [NUM_W-1:0] nz_num;
    logic [NUM_W-1:0] act_num;
    logic [IDX_W-1:0] lo_idx, hi_idx, keep_idx, drop_idx;
    logic             lo_ok, hi_ok;
    logic [WW-1:0]    sum_w;
    logic [NUM_W-1:0] min_tag;
    logic [NSYM-1:0]  lo_mem, hi_mem;

    // Lighter weight is smaller; on equal weight the higher tag counts as smaller.
    function automatic logic smaller(input logic [WW-1:0] wa, input logic [NUM_W-1:0] ta,
                                     input logic [WW-1:0] wb, input logic [NUM_W-1:0] tb);
        return (wa < wb) || ((wa == wb) && (ta > tb));
    endfunction

    always_comb begin
        hit     = '0;
        nonzero = '0;
        nz_num  = '0;
        for (int i = 0; i < NSYM; i++) begin
            hit[i]     = gray_valid && (gray_data == SYM_W'(i + 1));
            nonzero[i] = (cnt[i] != '0);
            if (nonzero[i]) nz_num = nz_num + NUM_W'(1);
        end
    end

    always_comb begin
        lo_idx  = '0;
        hi_idx  = '0;
        lo_ok   = 1'b0;
        hi_ok   = 1'b0;
        act_num = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (active[i]) begin
                act_num = act_num + NUM_W'(1);
                if (!lo_ok || smaller(weight[i], tag[i], weight[lo_idx], tag[lo_idx])) begin
                    hi_idx = lo_idx;
                    hi_ok  = lo_ok;
                    lo_idx = IDX_W'(i);
                    lo_ok  = 1'b1;
                end else if (!hi_ok || smaller(weight[i], tag[i], weight[hi_idx], tag[hi_idx])) begin
                    hi_idx = IDX_W'(i);
                    hi_ok  = 1'b1;
                end
            end
        end
        keep_idx = (lo_idx < hi_idx) ? lo_idx : hi_idx;
        drop_idx = (lo_idx < hi_idx) ? hi_idx : lo_idx;
    end

    assign sum_w   = weight[lo_idx] + weight[hi_idx];
    assign min_tag = (tag[lo_idx] < tag[hi_idx]) ? tag[lo_idx] : tag[hi_idx];
    assign lo_mem  = members[lo_idx];
    assign hi_mem  = members[hi_idx];

    always_comb begin
        state_next = state;
        cnt_valid  = 1'b0;
        code_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (gray_valid) state_next = RECV;
            RECV:    if (!gray_valid) state_next = CNT_OUT;
            CNT_OUT: begin
                cnt_valid  = 1'b1;
                state_next = (nz_num >= NUM_W'(2)) ? BUILD : DONE;
            end
            BUILD:   if (act_num <= NUM_W'(2)) state_next = DONE;
            DONE: begin
                code_valid = 1'b1;
                if (code_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_sat <= 1'b0;
            active  <= '0;
            for (int i = 0; i < NSYM; i++) begin
                cnt[i]     <= '0;
                weight[i]  <= '0;
                tag[i]     <= '0;
                members[i] <= '0;
                hc[i]      <= '0;
                m[i]       <= '0;
            end
        end else begin
            case (state)
                IDLE: if (gray_valid) begin
                    cnt_sat <= 1'b0;
                    for (int i = 0; i < NSYM; i++) cnt[i] <= hit[i] ? CNT_W'(1) : '0;
                end
                RECV: for (int i = 0; i < NSYM; i++) begin
                    if (hit[i]) begin
                        if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
                        if (cnt[i] >= CNT_MAX - CNT_W'(1)) cnt_sat <= 1'b1;
                    end
                end
                // A lone symbol still needs a 1-bit code, hence mask 1 when k==1.
                CNT_OUT: begin
                    active <= nonzero;
                    for (int i = 0; i < NSYM; i++) begin
                        weight[i]  <= WW'(cnt[i]);
                        tag[i]     <= NUM_W'(i + 1);
                        members[i] <= NSYM'(1) << i;
                        hc[i]      <= '0;
                        m[i]       <= (nonzero[i] && nz_num == NUM_W'(1)) ? CODE_W'(1) : '0;
                    end
                end
                // Masks are always low-len ones, so m+1 is exactly 1<<len.
                BUILD: if (lo_ok && hi_ok) begin
                    weight[keep_idx]  <= sum_w;
                    tag[keep_idx]     <= min_tag;
                    members[keep_idx] <= lo_mem | hi_mem;
                    active[drop_idx]  <= 1'b0;
                    for (int j = 0; j < NSYM; j++) begin
                        if (lo_mem[j]) begin
                            hc[j] <= hc[j] | (m[j] + CODE_W'(1));
                            m[j]  <= (m[j] << 1) | CODE_W'(1);
                        end else if (hi_mem[j]) begin
                            m[j]  <= (m[j] << 1) | CODE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_flat = '0;
        hc_flat  = '0;
        m_flat   = '0;
        for (int i = 0; i < NSYM; i++) begin
            cnt_flat[i*CNT_W +: CNT_W]  = cnt[i];
            hc_flat[i*CODE_W +: CODE_W] = hc[i];
            m_flat[i*CODE_W +: CODE_W]  = m[i];
        end
    end

endmodule

// File: tb/tb_huffman_param_encoder.sv
// Directed bench: a default NSYM=6 encoder and an NSYM=4/CODE_W=4 encoder share
// stimulus; sel4 picks which instance the frame checks observe.
module tb_huffman_param_encoder;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       gray_valid = 1'b0;
    logic [7:0] gray_data  = 8'd0;
    logic       code_ack   = 1'b0;
    logic       sel4       = 1'b0;
    int         checks     = 0;
    int         errors     = 0;

    logic        cnt_valid6, cnt_sat6, code_valid6, busy6;
    logic [47:0] cnt_flat6, hc_flat6, m_flat6;
    logic        cnt_valid4, cnt_sat4, code_valid4, busy4;
    logic [31:0] cnt_flat4;
    logic [15:0] hc_flat4, m_flat4;

    huffman_param_encoder dut6 (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
        .cnt_valid(cnt_valid6), .cnt_flat(cnt_flat6), .cnt_sat(cnt_sat6),
        .code_valid(code_valid6), .code_ack(code_ack), .hc_flat(hc_flat6),
        .m_flat(m_flat6), .busy(busy6)
    );

    huffman_param_encoder #(.NSYM(4), .CODE_W(4)) dut4 (
        .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
        .cnt_valid(cnt_valid4), .cnt_flat(cnt_flat4), .cnt_sat(cnt_sat4),
        .code_valid(code_valid4), .code_ack(code_ack), .hc_flat(hc_flat4),
        .m_flat(m_flat4), .busy(busy4)
    );

    always #5 clk = ~clk;

    logic [127:0] cnt_s, hc_s, m_s;
    logic         cnt_valid_s, code_valid_s, busy_s, sat_s;
    assign cnt_s        = sel4 ? 128'(cnt_flat4) : 128'(cnt_flat6);
    assign hc_s         = sel4 ? 128'(hc_flat4)  : 128'(hc_flat6);
    assign m_s          = sel4 ? 128'(m_flat4)   : 128'(m_flat6);
    assign cnt_valid_s  = sel4 ? cnt_valid4  : cnt_valid6;
    assign code_valid_s = sel4 ? code_valid4 : code_valid6;
    assign busy_s       = sel4 ? busy4       : busy6;
    assign sat_s        = sel4 ? cnt_sat4    : cnt_sat6;

    localparam logic [47:0] CNT_T1 = 48'h01_01_02_03_04_05;
    localparam logic [47:0] HC_T1  = 48'h0B_0A_04_03_01_00;
    localparam logic [47:0] M_T1   = 48'h0F_0F_07_03_03_03;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic doReset();
        reset      = 1'b1;
        gray_valid = 1'b0;
        gray_data  = 8'd0;
        code_ack   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] sym, input int n);
        repeat (n) begin
            gray_valid = 1'b1;
            gray_data  = sym;
            tick();
        end
    endtask

    task automatic streamT1();
        applyStimulus(8'd1, 5);
        applyStimulus(8'd2, 4);
        applyStimulus(8'd3, 3);
        applyStimulus(8'd4, 2);
        applyStimulus(8'd5, 1);
        applyStimulus(8'd6, 1);
    endtask

    // Ends the stream, checks the cnt_valid pulse and counts BUILD cycles up to code_valid.
    task automatic endFrame(input logic [127:0] exp_cnt, input int exp_build);
        int n;
        gray_valid = 1'b0;
        gray_data  = 8'd0;
        n = 0;
        while (!cnt_valid_s && n < 50) begin
            tick();
            n++;
        end
        checkOutput("cnt_valid_seen", 128'(cnt_valid_s), 128'(1));
        checkOutput("cnt_at_cnt_valid", cnt_s, exp_cnt);
        tick();
        checkOutput("cnt_valid_pulse", 128'(cnt_valid_s), 128'(0));
        n = 0;
        while (!code_valid_s && n < 50) begin
            tick();
            n++;
        end
        checkOutput("code_valid_seen", 128'(code_valid_s), 128'(1));
        checkOutput("build_cycles", 128'(n), 128'(exp_build));
    endtask

    task automatic checkCodes(input logic [127:0] exp_hc, input logic [127:0] exp_m, input logic exp_sat);
        checkOutput("hc_flat", hc_s, exp_hc);
        checkOutput("m_flat", m_s, exp_m);
        checkOutput("cnt_sat", 128'(sat_s), 128'(exp_sat));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"}, 128'(busy_s), 128'(0));
        checkOutput({name, "_code_valid"}, 128'(code_valid_s), 128'(0));
        checkOutput({name, "_cnt_valid"}, 128'(cnt_valid_s), 128'(0));
        checkOutput({name, "_cnt"}, cnt_s, 128'(0));
        checkOutput({name, "_hc"}, hc_s, 128'(0));
        checkOutput({name, "_m"}, m_s, 128'(0));
        checkOutput({name, "_sat"}, 128'(sat_s), 128'(0));
    endtask

    initial begin
        logic stable;

        doReset();
        checkAllZero("reset");

        // Main frame: counts 5,4,3,2,1,1
        streamT1();
        endFrame(128'(CNT_T1), 5);
        checkCodes(128'(HC_T1), 128'(M_T1), 1'b0);

        // Hold in DONE with no ack while injecting samples
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            gray_valid = 1'b1;
            gray_data  = 8'((i % 6) + 1);
            tick();
            stable = stable & code_valid_s & busy_s & (hc_s == 128'(HC_T1)) &
                     (m_s == 128'(M_T1)) & (cnt_s == 128'(CNT_T1)) & !sat_s;
        end
        gray_valid = 1'b0;
        checkOutput("hold_stable", 128'(stable), 128'(1));
        checkOutput("hold_counts", cnt_s, 128'(CNT_T1));
        code_ack = 1'b1;
        tick();
        code_ack = 1'b0;
        checkOutput("ack_code_valid", 128'(code_valid_s), 128'(0));
        checkOutput("ack_busy", 128'(busy_s), 128'(0));
        checkOutput("idle_counts_held", cnt_s, 128'(CNT_T1));
        tick();
        checkOutput("idle_stays", 128'(busy_s), 128'(0));

        // Single symbol
        doReset();
        applyStimulus(8'd3, 7);
        endFrame(128'(48'h00_00_00_07_00_00), 0);
        checkCodes(128'(0), 128'(48'h00_00_00_01_00_00), 1'b0);

        // Saturation
        doReset();
        applyStimulus(8'd2, 300);
        endFrame(128'(48'h00_00_00_00_FF_00), 0);
        checkCodes(128'(0), 128'(48'h00_00_00_00_01_00), 1'b1);

        // Out-of-range only: k=0
        doReset();
        applyStimulus(8'd0, 1);
        applyStimulus(8'd7, 1);
        applyStimulus(8'd255, 1);
        endFrame(128'(0), 0);
        checkCodes(128'(0), 128'(0), 1'b0);

        // Reset during the 3rd BUILD cycle, then a clean frame
        doReset();
        streamT1();
        gray_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checkOutput("mid_build_busy", 128'(busy_s), 128'(1));
        checkOutput("mid_build_code_valid", 128'(code_valid_s), 128'(0));
        reset = 1'b1;
        tick();
        checkAllZero("mid_reset");
        reset = 1'b0;
        streamT1();
        endFrame(128'(CNT_T1), 5);
        checkCodes(128'(HC_T1), 128'(M_T1), 1'b0);

        // NSYM=4, CODE_W=4 instance: counts 1,1,1,1
        sel4 = 1'b1;
        doReset();
        applyStimulus(8'd1, 1);
        applyStimulus(8'd2, 1);
        applyStimulus(8'd3, 1);
        applyStimulus(8'd4, 1);
        endFrame(128'(32'h01_01_01_01), 3);
        checkCodes(128'(16'h3210), 128'(16'h3333), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
